// File: rtl/desc_alloc_ctrl.sv
// Descriptor slot allocator: grants free slot indices round-robin and tracks
// per-slot busy state, releasing slots on indexed completion events.
module desc_alloc_ctrl #(
  parameter  int unsigned MAX_DESC = 16,
  localparam int unsigned IDX_W    = $clog2(MAX_DESC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_req,
  output logic                alloc_rdy,
  output logic                alloc_vld,
  output logic [IDX_W-1:0]    alloc_idx,
  input  logic                done_vld,
  input  logic [IDX_W-1:0]    done_idx,
  input  logic                flush,
  output logic [MAX_DESC-1:0] busy,
  output logic [IDX_W:0]      free_cnt,
  output logic                err_done
);

  localparam logic [IDX_W:0]   MAX_CNT  = (IDX_W+1)'(MAX_DESC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_DESC - 1);

  logic [MAX_DESC-1:0] busy_q, busy_d;
  logic [IDX_W:0]      free_q, free_d;
  logic [IDX_W-1:0]    rr_q, rr_d, idx_q, idx_d, sel_idx;
  logic                vld_q, vld_d, err_q, err_d;
  logic                grant, found, done_in_range, done_ok;

  assign alloc_rdy     = (free_q != '0) && !flush;
  assign grant         = alloc_req && alloc_rdy;
  assign done_in_range = {1'b0, done_idx} < MAX_CNT;
  assign done_ok       = done_vld && done_in_range && busy_q[done_idx];

  // First free slot at or above rr_q, wrapping; only the registered busy
  // vector is searched, so a slot freed this cycle cannot be granted.
  always_comb begin
    int unsigned      p;
    logic [IDX_W-1:0] cand;
    sel_idx = '0;
    found   = 1'b0;
    p       = 0;
    cand    = '0;
    for (int unsigned k = 0; k < MAX_DESC; k++) begin
      p = int'(rr_q) + k;
      if (p >= MAX_DESC) p = p - MAX_DESC;
      cand = IDX_W'(p);
      if (!found && !busy_q[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    free_d = free_q;
    rr_d   = rr_q;
    idx_d  = idx_q;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    if (flush) begin
      busy_d = '0;
      free_d = MAX_CNT;
      rr_d   = '0;
    end else begin
      if (done_ok) busy_d[done_idx] = 1'b0;
      if (grant) begin
        busy_d[sel_idx] = 1'b1;
        vld_d           = 1'b1;
        idx_d           = sel_idx;
        rr_d            = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
      end
      free_d = free_q - (IDX_W+1)'(grant) + (IDX_W+1)'(done_ok);
      err_d  = done_vld && !done_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      free_q <= MAX_CNT;
      rr_q   <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      free_q <= free_d;
      rr_q   <= rr_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  assign busy      = busy_q;
  assign free_cnt  = free_q;
  assign alloc_vld = vld_q;
  assign alloc_idx = idx_q;
  assign err_done  = err_q;

endmodule
